// File: rtl/text_writer.sv
// Terminal-style writer for the screen character RAM: cursor tracking, wrap, CR/LF/BS/FF and scroll-by-one-line.
// Optional build macro TEXT_WRITER_TAB_EN enables TAB (0x09) stops every 8 columns.
module text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [4:0]        top_row,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row
);

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LP_LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [6:0]        LP_COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]        LP_ROW_MAX   = 5'(ROWS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [4:0]        r_clr_row;

  logic [5:0]        w_row_sum;
  logic [4:0]        w_phys_row;
  logic [4:0]        w_top_next;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_clr_line_addr;
  logic              w_accept;
  logic              w_printable;
  logic              w_wrap;
  logic              w_newline;
`ifdef TEXT_WRITER_TAB_EN
  logic [7:0]        w_tab_sum;
  logic [6:0]        w_tab_col;
`endif

  assign in_ready = (r_state == IDLE);

  // Logical-to-physical row mapping with a compare-and-subtract instead of a modulo.
  always_comb begin
    w_row_sum = {1'b0, cursor_row} + {1'b0, top_row};
    if (w_row_sum >= 6'(ROWS)) begin
      w_phys_row = 5'(w_row_sum - 6'(ROWS));
    end else begin
      w_phys_row = w_row_sum[4:0];
    end
    if (top_row == LP_ROW_MAX) begin
      w_top_next = 5'd0;
    end else begin
      w_top_next = top_row + 5'd1;
    end
  end

  assign w_cur_addr      = ADDR_W'(w_phys_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);
  assign w_clr_line_addr = ADDR_W'(r_clr_row) * ADDR_W'(COLS) + r_cnt;
  assign w_accept        = in_valid & in_ready;
  assign w_printable     = (in_char >= 8'h20) && (in_char != 8'h7F);
  assign w_wrap          = w_printable && (cursor_col == LP_COL_MAX);
  assign w_newline       = w_wrap || (in_char == 8'h0A);

`ifdef TEXT_WRITER_TAB_EN
  assign w_tab_sum = {1'b0, cursor_col[6:3], 3'b000} + 8'd8;
  assign w_tab_col = (w_tab_sum >= 8'(COLS)) ? LP_COL_MAX : w_tab_sum[6:0];
`endif

  // Main FSM: screen clear, byte interpretation and single-line clear after a scroll.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLEAR_ALL;
      r_cnt      <= '0;
      r_clr_row  <= 5'd0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_char    <= 8'h20;
      top_row    <= 5'd0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        CLEAR_ALL: begin
          wr_en   <= 1'b1;
          wr_addr <= r_cnt;
          wr_char <= 8'h20;
          if (r_cnt == LP_LAST_ADDR) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            top_row    <= 5'd0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        CLEAR_LINE: begin
          wr_en   <= 1'b1;
          wr_addr <= w_clr_line_addr;
          wr_char <= 8'h20;
          if (r_cnt == LP_LAST_COL) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              wr_en   <= 1'b1;
              wr_addr <= w_cur_addr;
              wr_char <= in_char;
              cursor_col <= w_wrap ? 7'd0 : cursor_col + 7'd1;
            end else begin
              case (in_char)
                8'h0D: cursor_col <= 7'd0;
                8'h08: cursor_col <= (cursor_col != 7'd0) ? cursor_col - 7'd1 : cursor_col;
                8'h0C: begin
                  r_state <= CLEAR_ALL;
                  r_cnt   <= '0;
                end
`ifdef TEXT_WRITER_TAB_EN
                8'h09: cursor_col <= w_tab_col;
`endif
                default: r_cnt <= r_cnt;
              endcase
            end
            // The bottom row scrolls by moving top_row; the old top becomes the new blank bottom row.
            if (w_newline) begin
              if (cursor_row != LP_ROW_MAX) begin
                cursor_row <= cursor_row + 5'd1;
              end else begin
                top_row   <= w_top_next;
                r_clr_row <= top_row;
                r_cnt     <= '0;
                r_state   <= CLEAR_LINE;
              end
            end
          end
        end
        default: begin
          r_state <= CLEAR_ALL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: a screen-level model predicts every RAM write and the cursor/scroll state.
module tb_text_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 24;
  localparam int ADDR_W = 12;
`ifdef TEXT_WRITER_TAB_EN
  localparam bit TAB_EN = 1'b1;
`else
  localparam bit TAB_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_char;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic [4:0]        top_row;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .top_row    (top_row),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  logic [19:0] exp_q[$];
  int          mcol, mrow, mtop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the next predicted write.
  always @(negedge clk) begin : monitor
    logic [19:0] e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d char %02h, none expected", wr_addr, wr_char);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(wr_addr), 32'(e[19:8]));
        chk("write_char", 32'(wr_char), 32'(e[7:0]));
      end
    end
  end

  function automatic void push_w(input int a, input int c);
    logic [11:0] aa;
    logic [7:0]  cc;
    aa = a[11:0];
    cc = c[7:0];
    exp_q.push_back({aa, cc});
  endfunction

  function automatic void model_clear_all();
    for (int a = 0; a < COLS * ROWS; a++) push_w(a, 32);
    mcol = 0;
    mrow = 0;
    mtop = 0;
  endfunction

  function automatic void model_newline();
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
      for (int c = 0; c < COLS; c++) push_w(mtop * COLS + c, 32);
      mtop = (mtop + 1) % ROWS;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b != 8'h7F) begin
      push_w(((mrow + mtop) % ROWS) * COLS + mcol, int'(b));
      if (mcol == COLS - 1) begin
        mcol = 0;
        model_newline();
      end else begin
        mcol++;
      end
    end else begin
      case (b)
        8'h0D: mcol = 0;
        8'h0A: model_newline();
        8'h08: if (mcol > 0) mcol--;
        8'h0C: model_clear_all();
        8'h09: if (TAB_EN) begin
          mcol = (mcol / 8 + 1) * 8;
          if (mcol > COLS - 1) mcol = COLS - 1;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_cursor(input string tag);
    chk({tag, "_col"}, 32'(cursor_col), mcol);
    chk({tag, "_row"}, 32'(cursor_row), mrow);
    chk({tag, "_top"}, 32'(top_row), mtop);
  endtask

  // Offer one byte, hold it until accepted, then advance the model.
  task automatic send(input logic [7:0] b);
    int w;
    in_valid = 1'b1;
    in_char  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 4000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (in_ready !== 1'b1) begin
      chk("accept_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_byte(b);
      if (b != 8'h0C) check_cursor("after_byte");
    end
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (in_ready !== 1'b1 && cycles < 4000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("ready_reached", 32'(in_ready), 1);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    check_cursor("at_ready");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_char", 32'(wr_char), 32'h20);
    chk("rst_top", 32'(top_row), 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset = 1'b0;
    model_clear_all();
  endtask

  function automatic logic [7:0] rand_printable();
    logic [7:0] p;
    p = 8'($urandom_range(32, 255));
    if (p == 8'h7F) p = 8'h80;
    return p;
  endfunction

  initial begin
    int cyc;
    int r;
    logic [7:0] b;
    clk = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_char = 8'h00;
    n_tests = 0;
    n_fail = 0;
    mcol = 0;
    mrow = 0;
    mtop = 0;

    do_reset();
    wait_ready(cyc);
    chk("clear_all_cycles", cyc, COLS * ROWS);

    send(8'h41);
    send(8'h42);
    chk("ab_col", 32'(cursor_col), 2);

    send(8'h0D);
    repeat (COLS - 1) send(8'($urandom_range(32, 126)));
    chk("col_at_edge", 32'(cursor_col), COLS - 1);
    send(8'h58);
    chk("wrap_col", 32'(cursor_col), 0);
    chk("wrap_row", 32'(cursor_row), 1);
    send(8'h08);
    chk("bs_col0", 32'(cursor_col), 0);
    chk("bs_row", 32'(cursor_row), 1);

    send(8'h0C);
    wait_ready(cyc);
    repeat (ROWS - 1) send(8'h0A);
    chk("lf_bottom_row", 32'(cursor_row), ROWS - 1);
    chk("lf_no_scroll", 32'(top_row), 0);
    send(8'h0A);
    chk("scroll_top", 32'(top_row), 1);
    chk("scroll_row", 32'(cursor_row), ROWS - 1);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("clear_line_cycles", cyc, COLS);
    send(8'h5A);

    send(8'h41);
    send(8'h0C);
    repeat (COLS * ROWS / 2) @(posedge clk);
    do_reset();
    wait_ready(cyc);
    chk("reclear_cycles", cyc, COLS * ROWS);
    chk("reclear_top", 32'(top_row), 0);

    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h09);
    chk("tab_from_3", 32'(cursor_col), TAB_EN ? 8 : 3);
    send(8'h0D);
    repeat (COLS - 2) send(rand_printable());
    send(8'h09);
    chk("tab_from_78", 32'(cursor_col), TAB_EN ? COLS - 1 : COLS - 2);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 199);
      if (r < 110)      b = rand_printable();
      else if (r < 140) b = 8'h0A;
      else if (r < 156) b = 8'h0D;
      else if (r < 170) b = 8'h08;
      else if (r < 180) b = 8'h09;
      else if (r < 198) begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h0C) b = 8'h7F;
      end else b = 8'h0C;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(b);
    end
    wait_ready(cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
